spi_flash_line_fetcher: RTL and testbench
=========================================

Name: spi_flash_line_fetcher

Overview:
- Self-contained SPI flash READ (03h) engine that fetches one line of NBITS bits from a 24-bit flash address into an internal line buffer.
- Sits directly upstream of the VGA pixel stage. The scanline controller issues a start during HBLANK; the pixel stage then shifts bits out MSB-first during the visible region.
- Replaces hpos-decoded SPI sequencing with a counter-driven FSM.

Parameters:
- NBITS, 120, data bits fetched per transaction and the line buffer depth.
- CMD, 8'h03, command byte sent MSB-first.

Ports:
- clk  in  1  system clock (pixel clock).
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- addr  in  24  flash byte address; latched with start.
- busy  out  1  high from the first SPI cycle through the done cycle.
- done  out  1  one-cycle pulse when the buffer is filled.
- buf_valid  out  1  buffer holds a complete fetch.
- pix_shift  in  1  advance the readout by one bit.
- pix_bit  out  1  current readout bit (buffer MSB).
- spi_cs  out  1  chip select, active HIGH, registered.
- spi_sclk  out  1  SPI clock, registered, idles low (mode 0).
- spi_mosi  out  1  registered.
- spi_miso  in  1  flash data.

Behaviour:
- Reset (async, rst_n=0): state IDLE; spi_cs=0, spi_sclk=0, spi_mosi=0; busy=0, done=0, buf_valid=0; buffer cleared; bit counter 0. Any transaction in progress is abandoned immediately.
- States: IDLE -> XFER -> DONE -> IDLE.
- SPI timing: one SPI bit takes 2 clk cycles (sclk low phase, then high phase); SCLK = clk/2.
- Edge numbering: E0 is the edge that samples start=1 in IDLE. It latches {CMD, addr} into a 32-bit TX shift register and clears buf_valid.
- E1: spi_cs=1, busy=1, spi_sclk=0, spi_mosi=TX[31].
- For bit index k (0..31+NBITS):
  - sclk is low after E(1+2k) and high after E(2+2k).
  - spi_mosi updates only on edges where sclk goes high->low.
  - MOSI carries the 32 command/address bits (k=0..31). For k>=32 MOSI is held 0.
- MISO sampling:
  - MISO is sampled on edges where sclk goes high->low, for k>=32 only.
  - Each sample is shifted into the buffer LSB, so the first data bit ends up at the MSB.
  - Data bit j (0-based) is therefore sampled at E(67+2j).
- Last sample, E(65+2*NBITS):
  - same edge: spi_cs<=0, spi_sclk stays 0, state DONE, done<=1, buf_valid<=1.
  - next edge: state IDLE, done<=0, busy<=0.
  - With NBITS=120, done is high for the cycle after E305.
- Start handling:
  - start outside IDLE (XFER or DONE) is ignored; no queuing.
  - start in the same cycle as DONE is ignored.
- Readout:
  - pix_bit = buf_valid ? buffer[NBITS-1] : 0.
  - pix_shift=1 while IDLE and buf_valid=1 shifts the buffer left, inserting 0.
  - pix_shift is ignored in XFER/DONE and when buf_valid=0.
  - After NBITS shifts pix_bit reads 0; buf_valid stays 1 until the next start.
- Counters: bit index counter sized clog2(32+NBITS) bits. The phase bit equals spi_sclk. Compare against 31+NBITS exactly; no wrap is allowed.
- Glitch-free: spi_cs, spi_sclk and spi_mosi come only from flops. spi_sclk is never high while spi_cs=0.

Test Plan:
- Reset mid-XFER: assert rst_n=0 at E40 -> all outputs 0 asynchronously (before the next edge). After release, busy=0 and buf_valid=0; a new start works normally.
- Basic fetch: addr=24'h000120, flash model returns bytes A5,3C,... (15 bytes) -> MOSI stream is 03 00 01 20 MSB-first with 32 SCLK rising edges.
  - done pulses exactly once after E305; busy is high from E1 through the done cycle.
  - spi_cs is high after E1 and low after E305, with exactly 152 SCLK rising edges in between.
- Readout: after the basic fetch, 120 pix_shift pulses -> pix_bit sequence equals 1010_0101_0011_1100... matching the model; the 121st read gives 0.
- Ignored start: pulse start with addr=24'hFFFFFF at E100 -> MOSI/address and timing unchanged; no second done.
- pix_shift during XFER: hold pix_shift=1 throughout the fetch -> buffer contents unaffected; first pix_bit after done = MSB of byte 0.
- Back-to-back: start on the cycle right after done falls, with addr=24'h000010 -> new transaction begins at the next edge; buf_valid goes 0 at the start edge and back to 1 at the new done.

Source files
------------

// File: rtl/spi_flash_line_fetcher.sv
`default_nettype none
// ============================================================================
// Module      : spi_flash_line_fetcher
// Description : SPI flash READ (03h) engine. Sends {CMD, addr} MSB-first, then
//               shifts NBITS data bits into a line buffer that the pixel stage
//               drains MSB-first one bit per pix_shift.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_flash_line_fetcher #(
    parameter int          NBITS = 120,
    parameter logic [7:0]  CMD   = 8'h03
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [23:0] addr,
    output logic        busy,
    output logic        done,
    output logic        buf_valid,
    input  logic        pix_shift,
    output logic        pix_bit,
    output logic        spi_cs,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    // Bit index covers 32 command/address bits plus NBITS data bits.
    localparam int            CW     = $clog2(32 + NBITS);
    localparam logic [CW-1:0] C_LAST = CW'(31 + NBITS);
    localparam logic [CW-1:0] C_DATA = CW'(32);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [31:0]      r_tx;
    logic [NBITS-1:0] r_buf;
    logic [CW-1:0]    r_cnt;

    // Readout is masked until a full line has landed in the buffer.
    assign pix_bit = buf_valid & r_buf[NBITS-1];

    // Transaction sequencer; spi_sclk doubles as the half-bit phase flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_tx      <= 32'd0;
            r_buf     <= '0;
            r_cnt     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            buf_valid <= 1'b0;
            spi_cs    <= 1'b0;
            spi_sclk  <= 1'b0;
            spi_mosi  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_tx      <= {CMD, addr};
                        r_cnt     <= '0;
                        buf_valid <= 1'b0;
                        r_state   <= S_XFER;
                    end else if (pix_shift && buf_valid) begin
                        r_buf <= {r_buf[NBITS-2:0], 1'b0};
                    end
                end
                S_XFER: begin
                    if (!spi_cs) begin
                        // First cycle after the start edge: open the frame.
                        spi_cs   <= 1'b1;
                        busy     <= 1'b1;
                        spi_sclk <= 1'b0;
                        spi_mosi <= r_tx[31];
                    end else if (!spi_sclk) begin
                        spi_sclk <= 1'b1;
                    end else begin
                        // Falling edge: next MOSI bit (zeros once TX drains), sample MISO.
                        spi_sclk <= 1'b0;
                        r_tx     <= {r_tx[30:0], 1'b0};
                        spi_mosi <= r_tx[30];
                        if (r_cnt >= C_DATA) begin
                            r_buf <= {r_buf[NBITS-2:0], spi_miso};
                        end
                        if (r_cnt == C_LAST) begin
                            spi_cs    <= 1'b0;
                            done      <= 1'b1;
                            buf_valid <= 1'b1;
                            r_state   <= S_DONE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_line_fetcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_flash_line_fetcher
// Description : Directed bench with a behavioural SPI flash model for
//               spi_flash_line_fetcher.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_flash_line_fetcher;

    localparam int NBITS = 120;
    localparam logic [NBITS-1:0] D0 = 120'hA53C5AC30FF0123456789ABCDE817E;
    localparam logic [NBITS-1:0] D1 = 120'hF00123456789ABCDEF001122334455;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [23:0] addr = 24'd0;
    logic        pix_shift = 1'b0;
    logic        spi_miso = 1'b0;
    logic        busy, done, buf_valid, pix_bit, spi_cs, spi_sclk, spi_mosi;

    int checks = 0;
    int failures = 0;
    int sclk_cnt = 0;
    int done_cnt = 0;
    int late_mosi = 0;
    int sclk_nocs = 0;
    int bad = 0;
    logic [31:0]      mosi_word = 32'd0;
    logic [NBITS-1:0] line = '0;

    spi_flash_line_fetcher #(.NBITS(NBITS), .CMD(8'h03)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .addr      (addr),
        .busy      (busy),
        .done      (done),
        .buf_valid (buf_valid),
        .pix_shift (pix_shift),
        .pix_bit   (pix_bit),
        .spi_cs    (spi_cs),
        .spi_sclk  (spi_sclk),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso)
    );

    always #5 clk = ~clk;

    // New frame: restart the flash model's bit counter.
    always @(posedge spi_cs) begin
        sclk_cnt  = 0;
        late_mosi = 0;
        mosi_word = 32'd0;
    end

    // Flash model: capture command/address, then present data bits.
    always @(posedge spi_sclk) begin
        if (!spi_cs) sclk_nocs++;
        if (sclk_cnt < 32) mosi_word = {mosi_word[30:0], spi_mosi};
        else if (spi_mosi) late_mosi++;
        if (sclk_cnt == 31) line = (mosi_word[23:0] == 24'h000120) ? D0 : D1;
        if (sclk_cnt >= 32 && sclk_cnt < 32 + NBITS)
            spi_miso = line[NBITS-1-(sclk_cnt-32)];
        sclk_cnt++;
    end

    // Count cycles with done high.
    always @(posedge clk) if (done) done_cnt++;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---- reset state
        #2;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_bufv", buf_valid, 1'b0);
        check("rst_io", {spi_cs, spi_sclk, spi_mosi, pix_bit}, 4'b0000);
        @(negedge clk); rst_n = 1'b1;

        // ---- reset mid-transfer at E40
        @(negedge clk); addr = 24'h000120; start = 1'b1;
        tick(); start = 1'b0;               // E0
        repeat (40) tick();                 // E40
        check("e40_busy_sclk", {busy, spi_cs, spi_sclk}, 3'b111);
        rst_n = 1'b0;
        #1;
        check("async_rst", {busy, done, buf_valid, spi_cs, spi_sclk, spi_mosi, pix_bit}, 7'd0);
        @(negedge clk); tick();
        @(negedge clk); rst_n = 1'b1;
        tick();
        check("post_rst", {busy, buf_valid, spi_cs}, 3'b000);

        // ---- basic fetch, pix_shift held high, ignored start at E100
        done_cnt = 0;
        @(negedge clk); addr = 24'h000120; start = 1'b1; pix_shift = 1'b1;
        tick(); start = 1'b0;               // E0
        check("e0_cs_bufv", {spi_cs, buf_valid}, 2'b00);
        tick();                             // E1
        check("e1_state", {spi_cs, busy, spi_sclk, spi_mosi}, 4'b1100);
        bad = 0;
        for (int e = 2; e <= 305; e++) begin
            tick();
            if (e == 99)  begin start = 1'b1; addr = 24'hFFFFFF; end
            if (e == 100) start = 1'b0;
            if (e < 305 && (!busy || !spi_cs)) bad++;
            if (e == 304) check("e304_not_done", done, 1'b0);
        end
        check("e305_state", {done, spi_cs, spi_sclk, busy, buf_valid}, 5'b10011);
        tick();                             // E306
        pix_shift = 1'b0;
        check("e306_state", {done, busy}, 2'b00);
        check("busy_cs_span", bad, 0);
        check("sclk_rises", sclk_cnt, 152);
        check("mosi_word", mosi_word, 32'h03000120);
        check("mosi_late_zero", late_mosi, 0);
        check("sclk_without_cs", sclk_nocs, 0);
        repeat (4) tick();
        check("done_once", done_cnt, 1);
        check("first_pix", pix_bit, D0[NBITS-1]);

        // ---- readout of the whole line
        for (int i = 0; i < NBITS; i++) begin
            check($sformatf("pix_%0d", i), pix_bit, D0[NBITS-1-i]);
            pix_shift = 1'b1; tick(); pix_shift = 1'b0;
        end
        check("pix_drained", {pix_bit, buf_valid}, 2'b01);

        // ---- start during DONE ignored, then back-to-back start
        done_cnt = 0;
        @(negedge clk); addr = 24'h000200; start = 1'b1;
        tick(); start = 1'b0;               // E0
        repeat (305) tick();                // E305
        check("b2b_first_done", done, 1'b1);
        start = 1'b1; addr = 24'h000010;    // held across the DONE cycle
        tick();                             // E306 (DONE: ignored)
        check("done_start_ignored", {done, spi_cs}, 2'b00);
        tick();                             // E307 = new E0
        start = 1'b0;
        check("b2b_e0", {spi_cs, buf_valid}, 2'b00);
        tick();                             // new E1
        check("b2b_e1", {spi_cs, busy}, 2'b11);
        repeat (304) tick();                // new E305
        check("b2b_done", {done, buf_valid}, 2'b11);
        check("b2b_mosi_word", mosi_word, 32'h03000010);
        tick();
        check("b2b_done_count", done_cnt, 2);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("b2b_pix_%0d", i), pix_bit, D1[NBITS-1-i]);
            pix_shift = 1'b1; tick(); pix_shift = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
